wall_follow_loop_sequencer: RTL
===============================

# wall_follow_loop_sequencer

Sequences the wall-following PID loop. Captures range samples from the distance sensor and generates the PID sample strobe at a fixed loop period. Holds the PID gains and setpoint in shadow registers and watches for sensor timeouts. Mixes the signed PID correction into saturated left/right motor speed commands for the PWM stage. It sits between the sensor front end, the register/config port, the PID datapath and the motor drivers.

## Interface
- PID_INT_WIDTH, 8, gain width (unsigned)
- PV_WIDTH, 9, sensor/setpoint width (unsigned)
- CONTROL_WIDTH, 16, width of PID signed correction
- SPEED_WIDTH, 8, motor command width (unsigned)
- LOOP_PERIOD, 500000, clk cycles per PID update (≥4)
- TIMEOUT_LOOPS, 4, consecutive sample-less loop ticks before fault (≥1)
- CTRL_SHIFT, 4, arithmetic right shift applied to the PID correction
- BASE_SPEED, 128, nominal forward speed
- SETPOINT_INIT, 100, reset value of setpoint
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- run  in  1  operator enable (level)
- cfg_we  in  1  config write strobe
- cfg_addr  in  2  0=k_p, 1=k_i, 2=k_d, 3=setpoint
- cfg_wdata  in  PV_WIDTH  write data; gains take bits [PID_INT_WIDTH-1:0]
- sample_valid  in  1  one-cycle strobe, new range sample
- sample_data  in  PV_WIDTH  range sample
- control_in  in  CONTROL_WIDTH  signed correction from PID
- pid_en  out  1  PID enable
- pid_clk_en  out  1  one-cycle PID sample strobe
- k_p, k_i, k_d  out  PID_INT_WIDTH each  active gains
- setpoint  out  PV_WIDTH  active setpoint
- feedback  out  PV_WIDTH  latest captured sample
- motor_left, motor_right  out  SPEED_WIDTH  speed commands
- fault  out  1  sensor timeout latched
- state  out  2  IDLE=0, WAIT_SAMPLE=1, RUN=2, FAULT=3
- loop_count  out  16  ticks issued in RUN, wraps

## Operation
- All outputs register. Reset values: pid_en, pid_clk_en, gains, feedback, motors, fault, loop_count = 0; setpoint = SETPOINT_INIT; state = IDLE. Shadow gains reset to 0 and shadow setpoint to SETPOINT_INIT.
- Period counter: 0..LOOP_PERIOD-1. It runs in WAIT_SAMPLE and RUN and clears on entry to either. A tick occurs on the cycle the counter equals LOOP_PERIOD-1.
- FSM:
  - IDLE: run=1 → WAIT_SAMPLE.
  - WAIT_SAMPLE: sample_valid → RUN. Stale count reaching TIMEOUT_LOOPS → FAULT.
  - RUN: stale count reaching TIMEOUT_LOOPS → FAULT.
  - FAULT: held until run=0.
  - run=0 in any state → IDLE on the next edge. This has priority over all other transitions.
- pid_en = 1 only in RUN. pid_clk_en = tick AND RUN.
- sample_valid, in any state except IDLE, loads feedback and clears the stale count. Clearing has priority over a tick increment on the same cycle.
- Stale count: increments on each tick with no sample since the previous tick. It clears on entry to WAIT_SAMPLE.
- Config writes always land in the shadow registers.
  - Active copies track the shadows every cycle in IDLE, WAIT_SAMPLE and FAULT.
  - In RUN, active copies load from the shadows only on the tick cycle edge.
  - A write coincident with a tick reaches the active copy at the following tick.
- Mixing is done one cycle after each pid_clk_en (tick_d):
  - u = control_in >>> CTRL_SHIFT (sign-extended).
  - motor_left = clamp(BASE_SPEED + u, 0, 2^SPEED_WIDTH-1); motor_right = clamp(BASE_SPEED − u, 0, 2^SPEED_WIDTH-1).
  - Intermediate sums use CONTROL_WIDTH+2 signed bits, so they never wrap.
- Motors are 0 outside RUN. In RUN they hold their value between updates.
- fault = 1 exactly while state = FAULT.
- loop_count increments on every pid_clk_en and wraps at 0xFFFF→0.

## Timing
- Entry to RUN at edge E. The first pid_clk_en is high in cycle E+LOOP_PERIOD-1, then every LOOP_PERIOD cycles.
- Active gains and setpoint change at the same edge on which the PID registers its error (end of the tick cycle).
- control_in is sampled in the cycle after pid_clk_en. motor_left/motor_right change at the end of that cycle, two edges after the tick cycle begins.
- A sample coincident with a tick: the PID sees the previous feedback value on that tick, and the new value on the next tick.
- The FAULT transition occurs at the end of the tick cycle that makes the stale count reach TIMEOUT_LOOPS. pid_en and the motors are 0 from the next cycle.
- run dropped mid-loop: the next cycle is IDLE, pid_en=0, motors=0, and any pending tick_d update is discarded.
- A synchronous reset mid-operation restores all reset values at that edge.

## Test plan
All scenarios use LOOP_PERIOD=10, TIMEOUT_LOOPS=3, CTRL_SHIFT=2, BASE_SPEED=128.
- Reset, run=0, random config writes → state=0, pid_en=0, motors=0. Shadow writes appear on k_p/k_i/k_d/setpoint one edge after cfg_we.
- run=1, sample_valid with data 100 two cycles later → RUN, pid_en=1, feedback=100. pid_clk_en pulses exactly every 10 cycles; loop_count increments on each pulse.
- control_in = +40 / +800 / −800 at tick_d → (138,118) / (255,0) / (0,255).
- In RUN, write k_p=5 mid-period → k_p holds its old value until the tick edge, then reads 5. A write coincident with a tick lands at the following tick.
- Stop samples after RUN → fault=1 and state=3 after the 3rd sample-less tick; motors=0, pid_en=0. run=0 → IDLE next cycle; run=1 → WAIT_SAMPLE.
- run dropped one cycle after pid_clk_en → no motor update, motors=0. A sample coincident with a tick clears the stale count, and no fault occurs.

Source files
------------

// File: rtl/wall_follow_loop_sequencer.sv
// Wall-following PID loop sequencer.
// Counts out the PID loop period, captures range samples, holds the PID gains
// and setpoint in shadow registers that reach the PID only at loop boundaries,
// detects a sensor that has stopped reporting, and mixes the signed PID
// correction into saturated left/right motor speed commands.
module wall_follow_loop_sequencer #(
  parameter int PID_INT_WIDTH = 8,
  parameter int PV_WIDTH      = 9,
  parameter int CONTROL_WIDTH = 16,
  parameter int SPEED_WIDTH   = 8,
  parameter int LOOP_PERIOD   = 500000,
  parameter int TIMEOUT_LOOPS = 4,
  parameter int CTRL_SHIFT    = 4,
  parameter int BASE_SPEED    = 128,
  parameter int SETPOINT_INIT = 100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_addr,
  input  logic [PV_WIDTH-1:0]      cfg_wdata,
  input  logic                     sample_valid,
  input  logic [PV_WIDTH-1:0]      sample_data,
  input  logic [CONTROL_WIDTH-1:0] control_in,
  output logic                     pid_en,
  output logic                     pid_clk_en,
  output logic [PID_INT_WIDTH-1:0] k_p,
  output logic [PID_INT_WIDTH-1:0] k_i,
  output logic [PID_INT_WIDTH-1:0] k_d,
  output logic [PV_WIDTH-1:0]      setpoint,
  output logic [PV_WIDTH-1:0]      feedback,
  output logic [SPEED_WIDTH-1:0]   motor_left,
  output logic [SPEED_WIDTH-1:0]   motor_right,
  output logic                     fault,
  output logic [1:0]               state,
  output logic [15:0]              loop_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam int CNT_W   = $clog2(LOOP_PERIOD);
  localparam int STALE_W = $clog2(TIMEOUT_LOOPS + 1);
  localparam int SUM_W   = CONTROL_WIDTH + 2;

  localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(LOOP_PERIOD - 1);
  localparam logic [STALE_W-1:0]     STALE_LAST = STALE_W'(TIMEOUT_LOOPS - 1);
  localparam logic signed [SUM_W-1:0] BASE_S    = SUM_W'(BASE_SPEED);
  localparam logic signed [SUM_W-1:0] SPEED_MAX = SUM_W'((1 << SPEED_WIDTH) - 1);

  logic [CNT_W-1:0]         period_cnt, cnt_next;
  logic [STALE_W-1:0]       stale_cnt, stale_next;
  logic [1:0]               state_next;
  logic                     running, tick, stale_hit, sample_take, tick_d;
  logic [PID_INT_WIDTH-1:0] kp_sh, ki_sh, kd_sh, kp_sh_n, ki_sh_n, kd_sh_n;
  logic [PV_WIDTH-1:0]      sp_sh, sp_sh_n;
  logic signed [SUM_W-1:0]  ctrl_ext, u_shift, sum_l, sum_r;

  // Saturate a wide signed sum into the unsigned motor command range.
  function automatic logic [SPEED_WIDTH-1:0] sat_speed(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1])        return '0;
    else if (v > SPEED_MAX) return '1;
    else                    return v[SPEED_WIDTH-1:0];
  endfunction

  // Next-state, period counter, stale counter and shadow write decode.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    running     = (state == ST_WAIT) || (state == ST_RUN);
    tick        = running && (period_cnt == CNT_LAST);
    sample_take = sample_valid && (state != ST_IDLE);
    stale_hit   = tick && !sample_valid && (stale_cnt == STALE_LAST);

    state_next = state;
    if (!run) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_WAIT;
        ST_WAIT:  if (sample_valid) state_next = ST_RUN;
                  else if (stale_hit) state_next = ST_FAULT;
        ST_RUN:   if (stale_hit) state_next = ST_FAULT;
        default:  state_next = ST_FAULT;
      endcase
    end

    // The counter restarts on entry to WAIT_SAMPLE or RUN and wraps at each tick.
    cnt_next = '0;
    if ((state_next == ST_WAIT || state_next == ST_RUN) && state_next == state)
      cnt_next = tick ? '0 : period_cnt + 1'b1;

    // A sample wins over a tick on the same cycle.
    stale_next = stale_cnt;
    if (state_next == ST_WAIT && state != ST_WAIT) stale_next = '0;
    else if (sample_take)                          stale_next = '0;
    else if (tick)                                 stale_next = stale_cnt + 1'b1;

    kp_sh_n = kp_sh;
    ki_sh_n = ki_sh;
    kd_sh_n = kd_sh;
    sp_sh_n = sp_sh;
    if (cfg_we) begin
      case (cfg_addr)
        2'd0:    kp_sh_n = cfg_wdata[PID_INT_WIDTH-1:0];
        2'd1:    ki_sh_n = cfg_wdata[PID_INT_WIDTH-1:0];
        2'd2:    kd_sh_n = cfg_wdata[PID_INT_WIDTH-1:0];
        default: sp_sh_n = cfg_wdata;
      endcase
    end

    ctrl_ext = {{2{control_in[CONTROL_WIDTH-1]}}, control_in};
    u_shift  = ctrl_ext >>> CTRL_SHIFT;
    sum_l    = BASE_S + u_shift;
    sum_r    = BASE_S - u_shift;
  end

  // Sequencer state, counters and the PID strobe outputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state      <= ST_IDLE;
      period_cnt <= '0;
      stale_cnt  <= '0;
      pid_en     <= 1'b0;
      pid_clk_en <= 1'b0;
      fault      <= 1'b0;
      tick_d     <= 1'b0;
      loop_count <= '0;
    end else begin
      state      <= state_next;
      period_cnt <= cnt_next;
      stale_cnt  <= stale_next;
      pid_en     <= (state_next == ST_RUN);
      // Registered look-ahead so the strobe is high in the cycle the counter
      // sits at its last value.
      pid_clk_en <= (state_next == ST_RUN) && (cnt_next == CNT_LAST);
      fault      <= (state_next == ST_FAULT);
      tick_d     <= pid_clk_en;
      if (pid_clk_en) loop_count <= loop_count + 16'd1;
    end
  end

  // Shadow config registers and the active copies presented to the PID.
  always_ff @(posedge clk) begin
    if (reset) begin
      kp_sh    <= '0;
      ki_sh    <= '0;
      kd_sh    <= '0;
      sp_sh    <= PV_WIDTH'(SETPOINT_INIT);
      k_p      <= '0;
      k_i      <= '0;
      k_d      <= '0;
      setpoint <= PV_WIDTH'(SETPOINT_INIT);
    end else begin
      kp_sh <= kp_sh_n;
      ki_sh <= ki_sh_n;
      kd_sh <= kd_sh_n;
      sp_sh <= sp_sh_n;
      if (state != ST_RUN) begin
        // Outside RUN a write is visible on the very next edge.
        k_p      <= kp_sh_n;
        k_i      <= ki_sh_n;
        k_d      <= kd_sh_n;
        setpoint <= sp_sh_n;
      end else if (tick) begin
        // In RUN only the pre-edge shadow is taken, so a write coincident
        // with the tick waits for the following tick.
        k_p      <= kp_sh;
        k_i      <= ki_sh;
        k_d      <= kd_sh;
        setpoint <= sp_sh;
      end
    end
  end

  // Feedback capture and motor mixing one cycle after each PID strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      feedback    <= '0;
      motor_left  <= '0;
      motor_right <= '0;
    end else begin
      if (sample_take) feedback <= sample_data;
      if (state_next != ST_RUN) begin
        motor_left  <= '0;
        motor_right <= '0;
      end else if (tick_d) begin
        motor_left  <= sat_speed(sum_l);
        motor_right <= sat_speed(sum_r);
      end
    end
  end

endmodule
